// File: rtl/bram_reader_if.sv
// Stream/command/RAM-side signal bundle for bram_reader.
//   cmd_*   : burst command (start address, length) with valid/ready
//   raddr   : read address toward the bramsd instance
//   rdata   : read data from the bramsd instance (2-cycle latency)
//   out_*   : output word stream with valid/ready backpressure
//   busy    : engine has an accepted burst not yet fully delivered
// Modport master is the reader engine; slave is the RAM/consumer side.
interface bram_reader_if #(
  parameter int ADDR_ = 8,
  parameter int DATA_ = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [ADDR_-1:0] cmd_addr;
  logic [ADDR_:0]   cmd_len;
  logic [ADDR_-1:0] raddr;
  logic [DATA_-1:0] rdata;
  logic             out_valid;
  logic             out_ready;
  logic [DATA_-1:0] out_data;
  logic             out_last;
  logic             busy;

  modport master (
    input  cmd_valid, cmd_addr, cmd_len, rdata, out_ready,
    output cmd_ready, raddr, out_valid, out_data, out_last, busy
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_len, rdata, out_ready,
    input  cmd_ready, raddr, out_valid, out_data, out_last, busy
  );
endinterface

// File: rtl/bram_reader.sv
// Read-side burst engine for a bramsd semi dual port RAM.
// Accepts (start address, length) bursts, walks the RAM read address,
// tracks the fixed 2-cycle read latency with a tag shift register and
// buffers returned words in a 4-entry output FIFO (output register included)
// so the consumer can apply full backpressure.
// Ports:
//   clk  : clock shared with the bramsd instance
//   rst  : synchronous reset, active high
//   bus  : bram_reader_if.master (command, RAM address/data, stream, busy)
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// ISSUE | walking addresses, one read per cycle while credit allows
// DRAIN | all reads issued, waiting for tags, FIFO and output to empty
module bram_reader #(
  parameter int ADDR_ = 8,
  parameter int DATA_ = 8
) (
  input  logic           clk,
  input  logic           rst,
  bram_reader_if.master  bus
);

  localparam int          FIFO_DEPTH = 4;
  localparam logic [ADDR_:0] MAX_LEN = {1'b1, {ADDR_{1'b0}}};

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

  state_e           state_q, state_d;
  logic [ADDR_-1:0] cur_q, cur_d;
  logic [ADDR_:0]   rem_q, rem_d;
  logic             busy_q, busy_d;
  // Index 0 = one cycle after issue, index 1 = rdata valid this cycle.
  logic [1:0]       tv_q, tv_d;
  logic [1:0]       tl_q, tl_d;

  logic [DATA_-1:0] fifo_data_q [FIFO_DEPTH];
  logic [DATA_-1:0] fifo_data_d [FIFO_DEPTH];
  logic             fifo_last_q [FIFO_DEPTH];
  logic             fifo_last_d [FIFO_DEPTH];
  logic [1:0]       wr_ptr_q, wr_ptr_d;
  logic [1:0]       rd_ptr_q, rd_ptr_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             ov_q, ov_d;
  logic [DATA_-1:0] od_q, od_d;
  logic             ol_q, ol_d;

  logic             cmd_ready;
  logic             accept;
  logic [ADDR_:0]   len_clamp;
  logic [2:0]       used_w;
  logic             issue;
  logic             drained;
  logic             push, pop, load_out, from_buf, bypass, buf_wr;

  assign cmd_ready = (state_q == IDLE) && !rst;
  assign accept    = bus.cmd_valid && cmd_ready;
  assign len_clamp = (bus.cmd_len > MAX_LEN) ? MAX_LEN : bus.cmd_len;

  // Credit counts everything that will eventually need a FIFO slot:
  // buffered words, the output register and reads still in the RAM pipe.
  assign used_w  = cnt_q + 3'(ov_q) + 3'(tv_q[0]) + 3'(tv_q[1]);
  assign issue   = (state_q == ISSUE) && (used_w < 3'(FIFO_DEPTH));
  assign drained = (tv_q == 2'b00) && (cnt_q == 3'd0) && !ov_q;

  assign push     = tv_q[1];
  assign pop      = ov_q && bus.out_ready;
  assign load_out = !ov_q || pop;
  assign from_buf = load_out && (cnt_q != 3'd0);
  assign bypass   = load_out && (cnt_q == 3'd0) && push;
  assign buf_wr   = push && !bypass;

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    rem_d   = rem_q;
    busy_d  = busy_q;
    tv_d    = {tv_q[0], issue};
    tl_d    = {tl_q[0], issue && (rem_q == (ADDR_+1)'(1))};
    case (state_q)
      IDLE: begin
        if (accept && (bus.cmd_len != '0)) begin
          state_d = ISSUE;
          cur_d   = bus.cmd_addr;
          rem_d   = len_clamp;
          busy_d  = 1'b1;
        end
      end
      ISSUE: begin
        if (issue) begin
          cur_d = cur_q + 1'b1;
          rem_d = rem_q - 1'b1;
          if (rem_q == (ADDR_+1)'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (drained) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (pop && ol_q) busy_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cur_q   <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      tv_q    <= 2'b00;
      tl_q    <= 2'b00;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      tv_q    <= tv_d;
      tl_q    <= tl_d;
    end
  end

  // Output register is the FIFO head; a word arriving into an empty FIFO
  // goes straight into it so the first word appears one cycle after rdata.
  always_comb begin
    fifo_data_d = fifo_data_q;
    fifo_last_d = fifo_last_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    ov_d        = ov_q;
    od_d        = od_q;
    ol_d        = ol_q;
    if (buf_wr) begin
      fifo_data_d[wr_ptr_q] = bus.rdata;
      fifo_last_d[wr_ptr_q] = tl_q[1];
      wr_ptr_d              = wr_ptr_q + 2'd1;
    end
    if (from_buf) rd_ptr_d = rd_ptr_q + 2'd1;
    cnt_d = cnt_q + 3'(buf_wr) - 3'(from_buf);
    if (load_out) begin
      if (from_buf) begin
        ov_d = 1'b1;
        od_d = fifo_data_q[rd_ptr_q];
        ol_d = fifo_last_q[rd_ptr_q];
      end else if (push) begin
        ov_d = 1'b1;
        od_d = bus.rdata;
        ol_d = tl_q[1];
      end else begin
        ov_d = 1'b0;
        ol_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_q[i] <= '0;
        fifo_last_q[i] <= 1'b0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ov_q     <= 1'b0;
      od_q     <= '0;
      ol_q     <= 1'b0;
    end else begin
      fifo_data_q <= fifo_data_d;
      fifo_last_q <= fifo_last_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      ov_q        <= ov_d;
      od_q        <= od_d;
      ol_q        <= ol_d;
    end
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.raddr     = cur_q;
  assign bus.out_valid = ov_q;
  assign bus.out_data  = od_q;
  assign bus.out_last  = ol_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_bram_reader.sv
// Self-checking bench for bram_reader: a bramsd-like RAM model, a queue
// based reference of expected stream words, a stream monitor, a table of
// bursts and hand-written sequences for timing, reset and back-to-back cases.
module tb_bram_reader;
  localparam int ADDR_ = 8;
  localparam int DATA_ = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bram_reader_if #(.ADDR_(ADDR_), .DATA_(DATA_)) bus ();
  bram_reader #(.ADDR_(ADDR_), .DATA_(DATA_)) dut (.clk(clk), .rst(rst), .bus(bus));

  // RAM model: address register then output register.
  logic [7:0] mem [256];
  logic [7:0] ram_addr_q;
  always @(posedge clk) begin
    ram_addr_q <= bus.raddr;
    bus.rdata  <= mem[ram_addr_q];
  end

  typedef struct {
    logic [7:0] d;
    logic       l;
  } word_t;
  word_t expq[$];

  int checks = 0;
  int failures = 0;
  int pop_cnt, last_cnt;
  logic [7:0] first_d, fin_d;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic clear_stats();
    pop_cnt = 0;
    last_cnt = 0;
    first_d = 8'h00;
    fin_d = 8'h00;
  endtask

  // Reference: a burst yields min(len, 256) words from consecutive
  // addresses modulo 256, the final one flagged last.
  task automatic model_push(input logic [7:0] a, input logic [8:0] l);
    int n;
    word_t w;
    n = (int'(l) > 256) ? 256 : int'(l);
    for (int k = 0; k < n; k++) begin
      w.d = mem[(int'(a) + k) % 256];
      w.l = (k == n - 1);
      expq.push_back(w);
    end
  endtask

  // Ready driver: 0 = always ready, 1 = random, 2 = toggle then held low.
  int rdy_mode = 0;
  int rdy_t = 0;
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: bus.out_ready = 1'b1;
        1: bus.out_ready = ($urandom_range(0, 3) != 0);
        default: begin
          if (rdy_t < 16) bus.out_ready = (rdy_t % 2 == 0);
          else if (rdy_t < 26) bus.out_ready = 1'b0;
          else bus.out_ready = 1'b1;
          rdy_t++;
        end
      endcase
      if (rdy_mode != 2) rdy_t = 0;
    end
  end

  // Stream monitor.
  logic       hold_v = 1'b0;
  logic [7:0] hold_d;
  logic       hold_l;
  int         stall_run = 0;
  int         stall_chg = 0;
  logic [7:0] prev_raddr;
  always @(negedge clk) begin
    if (rst) begin
      hold_v = 1'b0;
      stall_run = 0;
      stall_chg = 0;
    end else begin
      if (hold_v) begin
        chk("hold_valid", 32'(bus.out_valid), 32'd1);
        chk("hold_data", 32'(bus.out_data), 32'(hold_d));
        chk("hold_last", 32'(bus.out_last), 32'(hold_l));
      end
      if (bus.out_valid && bus.out_ready) begin
        chk("expected_word_avail", 32'(expq.size() != 0), 32'd1);
        if (expq.size() != 0) begin
          word_t e;
          e = expq.pop_front();
          chk("word_data", 32'(bus.out_data), 32'(e.d));
          chk("word_last", 32'(bus.out_last), 32'(e.l));
        end
        pop_cnt++;
        if (pop_cnt == 1) first_d = bus.out_data;
        fin_d = bus.out_data;
        if (bus.out_last) last_cnt++;
      end
      hold_v = bus.out_valid && !bus.out_ready;
      hold_d = bus.out_data;
      hold_l = bus.out_last;
      chk("no_ready_while_busy", 32'(bus.busy && bus.cmd_ready), 32'd0);
      // With no pops, at most 4 more reads can be issued before credit runs out.
      if (!bus.out_ready && bus.busy) begin
        if (stall_run > 0 && bus.raddr !== prev_raddr) begin
          stall_chg++;
          chk("credit_stall", 32'(stall_chg <= 4), 32'd1);
        end
        stall_run++;
      end else begin
        stall_run = 0;
        stall_chg = 0;
      end
      prev_raddr = bus.raddr;
    end
  end

  task automatic do_burst(input logic [7:0] a, input logic [8:0] l, output int waited);
    bus.cmd_addr = a;
    bus.cmd_len = l;
    bus.cmd_valid = 1'b1;
    waited = 0;
    while (bus.cmd_ready !== 1'b1 && waited < 6000) begin
      @(posedge clk);
      #1;
      waited++;
    end
    chk("cmd_accept", 32'(bus.cmd_ready), 32'd1);
    model_push(a, l);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((expq.size() != 0 || bus.busy) && n < 6000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drained", {30'd0, expq.size() == 0, bus.busy}, 32'd2);
  endtask

  typedef struct {
    logic [7:0] addr;
    logic [8:0] len;
    int         mode;
    int         words;
    logic [7:0] first;
    logic [7:0] fin;
  } vec_t;
  vec_t vecs [8];

  initial begin
    #900000;
    $display("FAIL watchdog expired actual=running required=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int n;
    logic [7:0] ra;
    logic [8:0] rl;

    vecs[0] = '{8'h10, 9'd4,   0, 4,   8'h10, 8'h13};
    vecs[1] = '{8'hFE, 9'd4,   0, 4,   8'hFE, 8'h01};
    vecs[2] = '{8'h05, 9'd0,   0, 0,   8'h00, 8'h00};
    vecs[3] = '{8'hFF, 9'd2,   0, 2,   8'hFF, 8'h00};
    vecs[4] = '{8'h00, 9'd300, 0, 256, 8'h00, 8'hFF};
    vecs[5] = '{8'h80, 9'd256, 1, 256, 8'h80, 8'h7F};
    vecs[6] = '{8'h40, 9'd16,  2, 16,  8'h40, 8'h4F};
    vecs[7] = '{8'h33, 9'd1,   1, 1,   8'h33, 8'h33};

    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    bus.cmd_valid = 1'b0;
    bus.cmd_addr = '0;
    bus.cmd_len = '0;
    rst = 1'b1;
    clear_stats();

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("post_rst_busy", 32'(bus.busy), 32'd0);
    chk("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("post_rst_out_data", 32'(bus.out_data), 32'd0);
    chk("post_rst_out_last", 32'(bus.out_last), 32'd0);
    chk("post_rst_raddr", 32'(bus.raddr), 32'd0);
    @(posedge clk);
    #1;

    // Cycle-exact burst: accept in cycle 0, words in 4..7, busy low in 8.
    clear_stats();
    bus.cmd_addr = 8'h10;
    bus.cmd_len = 9'd4;
    bus.cmd_valid = 1'b1;
    model_push(8'h10, 9'd4);
    for (int c = 0; c < 10; c++) begin
      if (c == 1) bus.cmd_valid = 1'b0;
      @(negedge clk);
      if (c == 0) chk("t1_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      chk($sformatf("t1_valid_c%0d", c), 32'(bus.out_valid), 32'(c >= 4 && c <= 7));
      chk($sformatf("t1_last_c%0d", c), 32'(bus.out_last), 32'(c == 7));
      if (c >= 4 && c <= 7) chk($sformatf("t1_data_c%0d", c), 32'(bus.out_data), 32'(16 + c - 4));
      if (c >= 1) chk($sformatf("t1_busy_c%0d", c), 32'(bus.busy), 32'(c <= 7));
      @(posedge clk);
      #1;
    end

    // Table of bursts (mem[i] = i).
    for (int i = 0; i < 8; i++) begin
      rdy_mode = vecs[i].mode;
      clear_stats();
      do_burst(vecs[i].addr, vecs[i].len, w);
      if (vecs[i].len == 0) chk($sformatf("v%0d_len0_ready", i), 32'(bus.cmd_ready), 32'd1);
      drain();
      chk($sformatf("v%0d_count", i), 32'(pop_cnt), 32'(vecs[i].words));
      if (vecs[i].words > 0) begin
        chk($sformatf("v%0d_first", i), 32'(first_d), 32'(vecs[i].first));
        chk($sformatf("v%0d_final", i), 32'(fin_d), 32'(vecs[i].fin));
        chk($sformatf("v%0d_lastcnt", i), 32'(last_cnt), 32'd1);
      end
    end

    // Reset in the middle of a 20-word burst.
    rdy_mode = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    clear_stats();
    do_burst(8'h00, 9'd20, w);
    n = 0;
    while (pop_cnt < 5 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("rst_mid_pop5", 32'(pop_cnt), 32'd5);
    rst = 1'b1;
    expq.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_mid_busy", 32'(bus.busy), 32'd0);
    chk("rst_mid_out_last", 32'(bus.out_last), 32'd0);
    chk("rst_mid_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst_mid_no_last", 32'(last_cnt), 32'd0);
    @(posedge clk);
    #1;
    clear_stats();
    do_burst(8'h00, 9'd2, w);
    drain();
    chk("rst_after_count", 32'(pop_cnt), 32'd2);
    chk("rst_after_first", 32'(first_d), 32'h00);
    chk("rst_after_final", 32'(fin_d), 32'h01);

    // Command held valid during a burst, then back-to-back delivery.
    clear_stats();
    do_burst(8'h20, 9'd3, w);
    do_burst(8'h30, 9'd3, w);
    chk("b2b_wait_cycles", 32'(w), 32'd7);
    drain();
    chk("b2b_count", 32'(pop_cnt), 32'd6);
    chk("b2b_first", 32'(first_d), 32'h20);
    chk("b2b_final", 32'(fin_d), 32'h32);
    chk("b2b_lastcnt", 32'(last_cnt), 32'd2);

    // Random contents, bursts and backpressure.
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    rdy_mode = 1;
    for (int r = 0; r < 25; r++) begin
      ra = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) rl = 9'($urandom_range(257, 511));
      else rl = 9'($urandom_range(0, 24));
      do_burst(ra, rl, w);
      if ($urandom_range(0, 1) == 1) drain();
    end
    drain();
    rdy_mode = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("final_idle_ready", 32'(bus.cmd_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
